// File: rtl/tcm_arb_pkg.sv
// Shared constants and response-owner encoding for the TCM arbiter.
package tcm_arb_pkg;

    localparam int unsigned TCM_AW = 30;
    localparam int unsigned TCM_DW = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/tcm_arb_starve_cnt.sv
// Saturating count of consecutive refused fetch cycles.
// force_o asks the arbiter to hand the SRAM to the fetch port.
module tcm_arb_starve_cnt #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic force_o
);

    localparam logic [3:0] MAX_C = 4'(STARVE_MAX);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next count: clear wins over increment, increment stops at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (inc_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_o = (cnt_q == MAX_C);

endmodule

// File: rtl/tcm_arbiter.sv
// Arbitrates one single-port TCM SRAM between instruction fetch and data ports.
// Define TCM_ARB_STATS_EN to add the stat_conflicts / stat_forced counters.
module tcm_arbiter
    import tcm_arb_pkg::*;
#(
    parameter int unsigned AW         = TCM_AW,
    parameter int unsigned DW         = TCM_DW,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          core_stall
`ifdef TCM_ARB_STATS_EN
    ,
    output logic [31:0]   stat_conflicts,
    output logic [31:0]   stat_forced
`endif
);

    owner_e        resp_owner_q;
    owner_e        resp_owner_d;
    logic [DW-1:0] if_hold_q;
    logic [DW-1:0] d_hold_q;
    logic          force_s;

    tcm_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (if_req & d_gnt),
        .clr_i   (if_gnt | ~if_req),
        .force_o (force_s)
    );

    // Grant selection: data wins unless fetch has been starved long enough.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (rst) begin
            if_gnt = 1'b0;
            d_gnt  = 1'b0;
        end else if (if_req && (!d_req || force_s)) begin
            if_gnt = 1'b1;
        end else if (d_req) begin
            d_gnt = 1'b1;
        end else begin
            if_gnt = 1'b0;
            d_gnt  = 1'b0;
        end
    end

    // SRAM port is steered from whichever requester was granted.
    always_comb begin
        mem_en     = if_gnt | d_gnt;
        mem_we     = d_gnt & d_we;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end else begin
            mem_addr  = '0;
        end
        core_stall = (if_req & ~if_gnt) | (d_req & ~d_gnt);
    end

    // Owner of the read whose data comes back next cycle; writes own nothing.
    always_comb begin
        resp_owner_d = OWN_NONE;
        if (if_gnt) begin
            resp_owner_d = OWN_IF;
        end else if (d_gnt && !d_we) begin
            resp_owner_d = OWN_D;
        end else begin
            resp_owner_d = OWN_NONE;
        end
    end

    // Response owner and per-port last-delivered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_owner_q <= OWN_NONE;
            if_hold_q    <= '0;
            d_hold_q     <= '0;
        end else begin
            resp_owner_q <= resp_owner_d;
            if (resp_owner_q == OWN_IF) begin
                if_hold_q <= mem_rdata;
            end
            if (resp_owner_q == OWN_D) begin
                d_hold_q <= mem_rdata;
            end
        end
    end

    // A response landing in a reset cycle is dropped rather than delivered.
    always_comb begin
        if_rvalid = (resp_owner_q == OWN_IF) && !rst;
        d_rvalid  = (resp_owner_q == OWN_D) && !rst;
        if_rdata  = if_rvalid ? mem_rdata : if_hold_q;
        d_rdata   = d_rvalid ? mem_rdata : d_hold_q;
    end

`ifdef TCM_ARB_STATS_EN
    logic [31:0] stat_conflicts_q;
    logic [31:0] stat_forced_q;

    // Wrapping event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_conflicts_q <= 32'd0;
            stat_forced_q    <= 32'd0;
        end else begin
            stat_conflicts_q <= stat_conflicts_q + ((if_req && d_req) ? 32'd1 : 32'd0);
            stat_forced_q    <= stat_forced_q + ((if_gnt && d_req) ? 32'd1 : 32'd0);
        end
    end

    assign stat_conflicts = stat_conflicts_q;
    assign stat_forced    = stat_forced_q;
`endif

    // A waiting requester must keep its address and data stable.
    a_if_stable: assert property (@(posedge clk) disable iff (rst)
        (if_req && !if_gnt) |=> (!if_req || $stable(if_addr)));
    a_d_stable: assert property (@(posedge clk) disable iff (rst)
        (d_req && !d_gnt) |=> (!d_req || $stable({d_we, d_addr, d_wdata})));

endmodule
